ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port-pair word RAM.
// Each access takes the IDLE -> ISSUE -> [MERGE] -> RESP path. A partial write
// is a read-modify-write: the word is read in ISSUE and written back merged in MERGE.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | wait for a valid, pick a requester round-robin, latch its request
//  ISSUE | full write: ram_wen; read or partial write: ram_ren
//  MERGE | partial write: write back the old word with the enabled bytes replaced
//  RESP  | one-cycle ready to the granted requester, read data forwarded
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m0_valid,
   input  logic [31:0]           m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_wstrb,
   output logic                  m0_ready,
   output logic [31:0]           m0_rdata,
   input  logic                  m1_valid,
   input  logic [31:0]           m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_wstrb,
   output logic                  m1_ready,
   output logic [31:0]           m1_rdata,
   output logic                  ram_wen,
   output logic                  ram_ren,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_MERGE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]            state_q, state_d;
   // Last-granted requester (1 = m1). It also identifies the requester that
   // owns the transaction in flight, because it changes only on a grant.
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;

   logic                  gnt;
   logic                  full_wr;
   logic                  rd_resp;
   logic [31:0]           merged;

   // Only the word-address bits of the byte address reach the RAM.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                               m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

   // Next-state and request-latch logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      gnt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (m0_valid || m1_valid) begin
               // With both requesting, serve the one not granted last time.
               gnt     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
               last_d  = gnt;
               addr_d  = gnt ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
               wdata_d = gnt ? m1_wdata : m0_wdata;
               wstrb_d = gnt ? m1_wstrb : m0_wstrb;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wstrb_q == 4'hF || wstrb_q == 4'h0) state_d = S_RESP;
            else                                     state_d = S_MERGE;
         end
         S_MERGE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched request registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Byte merge of the latched write data over the word read back in ISSUE.
   always_comb begin
      merged = ram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // RAM and requester outputs decoded from state; all quiet in IDLE and reset.
   always_comb begin
      full_wr   = (wstrb_q == 4'hF);
      rd_resp   = (state_q == S_RESP) && (wstrb_q == 4'h0);
      ram_wen   = ((state_q == S_ISSUE) && full_wr) || (state_q == S_MERGE);
      ram_ren   = (state_q == S_ISSUE) && !full_wr;
      ram_waddr = addr_q;
      ram_raddr = addr_q;
      ram_wdata = (state_q == S_MERGE) ? merged : wdata_q;
      m0_ready  = (state_q == S_RESP) && !last_q;
      m1_ready  = (state_q == S_RESP) && last_q;
      m0_rdata  = (rd_resp && !last_q) ? ram_rdata : 32'h0;
      m1_rdata  = (rd_resp && last_q)  ? ram_rdata : 32'h0;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_wen, ram_ren;
   logic [7:0]  ram_waddr, ram_raddr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;

   logic [31:0] mem [0:255];

   int nvec = 0;
   int nerr = 0;

   ram_port_arbiter #(.ADDR_WIDTH(8)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      if (ram_ren) ram_rdata <= mem[ram_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int m, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      if (m == 0) begin
         m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
      end else begin
         m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ready"}, {30'h0, m1_ready, m0_ready}, 32'h0);
      chk({tag, "_wenren"}, {30'h0, ram_wen, ram_ren}, 32'h0);
   endtask

   // One complete access from an idle FSM, called at a negedge.
   // exp_ram: word written to the RAM (full or merged); exp_rd: read data.
   task automatic access(input int m, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp_ram,
                         input logic [31:0] exp_rd, input logic [7:0] exp_a);
      logic full;
      full = (ws == 4'hF);
      drive(m, 1'b1, addr, wd, ws);
      @(posedge clk); @(negedge clk);
      chk("issue_wen", ram_wen, full);
      chk("issue_ren", ram_ren, !full);
      chk("issue_addr", full ? ram_waddr : ram_raddr, exp_a);
      chk("issue_ready", {m1_ready, m0_ready}, 0);
      if (full) chk("issue_wdata", ram_wdata, exp_ram);
      if (!full && ws != 4'h0) begin
         @(negedge clk);
         chk("merge_wenren", {ram_wen, ram_ren}, 2'b10);
         chk("merge_waddr", ram_waddr, exp_a);
         chk("merge_wdata", ram_wdata, exp_ram);
      end
      @(negedge clk);
      chk("resp_ready", {m1_ready, m0_ready}, (m == 0) ? 2'b01 : 2'b10);
      chk("resp_wenren", {ram_wen, ram_ren}, 2'b00);
      chk("resp_other_rdata", (m == 0) ? m1_rdata : m0_rdata, 32'h0);
      if (ws == 4'h0) chk("resp_rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
      drive(m, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk_quiet("idle");
   endtask

   initial begin
      // Reset holds everything low even with a request pending.
      drive(0, 1'b1, 32'h10, 32'h12345678, 4'hF);
      repeat (3) @(negedge clk);
      chk_quiet("rst");
      chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      chk("rst_addr", {ram_waddr, ram_raddr}, 16'h0);
      chk("rst_wdata", ram_wdata, 32'h0);
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Full write then read back.
      access(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 8'h04);
      access(0, 32'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 8'h04);

      // Partial write merges one byte into the existing word.
      access(1, 32'h10, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 8'h04);
      access(1, 32'h10, 32'h0000AA00, 4'b0010, 32'h1122AA44, 32'h0, 8'h04);
      access(0, 32'h10, 32'h0, 4'h0, 32'h0, 32'h1122AA44, 8'h04);

      // Address wrap: 0x403 maps to word 0.
      access(0, 32'h0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 8'h00);
      access(1, 32'h403, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 8'h00);

      // Both requesting continuously: strict alternation starting with m0.
      drive(0, 1'b1, 32'h20, 32'h0, 4'h0);
      drive(1, 1'b1, 32'h24, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rr_raddr", ram_raddr, (i % 2 == 0) ? 8'h08 : 8'h09);
         @(negedge clk);
         chk("rr_ready", {m1_ready, m0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i == 3) begin
            drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
            drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
         end
         @(negedge clk);
         chk("rr_pulse", {m1_ready, m0_ready}, 2'b00);
      end

      // Lone requester wins even though it was granted last.
      access(1, 32'h10, 32'h0, 4'h0, 32'h0, 32'h1122AA44, 8'h04);

      // Reset during MERGE abandons the write.
      drive(0, 1'b1, 32'h10, 32'h000000FF, 4'b0001);
      @(posedge clk); @(negedge clk);
      chk("rm_issue_ren", ram_ren, 1'b1);
      @(negedge clk);
      chk("rm_merge_wdata", ram_wdata, 32'h1122AAFF);
      resetn = 1'b0;
      #1;
      chk_quiet("rm_rst");
      chk("rm_rst_wdata", ram_wdata, 32'h0);
      chk("rm_rst_addr", {ram_waddr, ram_raddr}, 16'h0);
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) begin
         @(negedge clk);
         chk_quiet("rm_hold");
      end
      resetn = 1'b1;
      @(negedge clk);
      access(0, 32'h10, 32'h0, 4'h0, 32'h0, 32'h1122AA44, 8'h04);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
